// File: rtl/bypass_bin_sched.sv
// bypass_bin_sched
//   Sequencer for the equiprobable (bypass) bin path of the arithmetic decoder.
//   It accepts a request for 1..MAX_BINS bypass bins and steps the bypass
//   datapath. It decodes one bin per cycle, or two per cycle when the
//   BYPASS_DUAL_BIN_EN macro is defined. It pulls in a bitstream byte whenever
//   bits_needed reaches -1. It returns the packed bins with the updated
//   m_value and bits_needed.
//
//   Optional feature macro: BYPASS_DUAL_BIN_EN (two-bin-per-cycle path).
//
// Ports
//   clk_i, rst_i               clock, asynchronous active-high reset
//   req_valid_i / req_ready_o  request handshake
//   req_num_i                  bins requested (0 treated as 1)
//   m_range_i, m_value_in_i,
//   bits_needed_in_i           arithmetic state, latched on accept
//   byte_valid_i / byte_ready_o, byte_data_i   bitstream byte handshake
//   bins_valid_o / bins_ready_i                result handshake
//   bins_data_o, bins_num_o, m_value_out_o, bits_needed_out_o   result
module bypass_bin_sched #(
   parameter int MAX_BINS = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [5:0]        req_num_i,
   input  logic [8:0]        m_range_i,
   input  logic [15:0]       m_value_in_i,
   input  logic signed [3:0] bits_needed_in_i,
   input  logic              byte_valid_i,
   output logic              byte_ready_o,
   input  logic [7:0]        byte_data_i,
   output logic              bins_valid_o,
   input  logic              bins_ready_i,
   output logic [31:0]       bins_data_o,
   output logic [5:0]        bins_num_o,
   output logic [15:0]       m_value_out_o,
   output logic signed [3:0] bits_needed_out_o
);

   typedef enum logic [1:0] {IDLE, DECODE, WAIT_BYTE, DONE} state_t;

   typedef struct packed {
      logic              bin;
      logic [15:0]       val;
      logic signed [3:0] bn;
   } res_t;

   localparam logic signed [3:0] BN_MIN = 4'sb1000;  // -8
   localparam logic signed [3:0] BN_INS = 4'sb1111;  // -1: next bin pulls a byte

   // One bypass bin: shift in a bit (plus a whole byte on an insert bin),
   // compare against the scaled range, subtract on a 1.
   function automatic res_t bin_step(input logic [15:0] val,
                                     input logic signed [3:0] bn,
                                     input logic [8:0] rng,
                                     input logic [7:0] byt,
                                     input logic ins);
      logic [16:0] v;
      logic [16:0] scaled;
      res_t        r;
      scaled = {1'b0, rng, 7'd0};
      v      = {val, 1'b0} + (ins ? {9'd0, byt} : 17'd0);
      r.bin  = (v >= scaled);
      r.val  = r.bin ? 16'(v - scaled) : v[15:0];
      r.bn   = ins ? BN_MIN : bn + 4'sd1;
      return r;
   endfunction

   state_t            state_q, state_d;
   logic [8:0]        range_q, range_d;
   logic [15:0]       value_q, value_d;
   logic signed [3:0] bn_q, bn_d;
   logic [5:0]        rem_q, rem_d;
   logic [5:0]        num_q, num_d;
   logic [31:0]       bins_q, bins_d;
   logic [5:0]        num_eff;
   logic              take1;
   res_t              s1;
`ifdef BYPASS_DUAL_BIN_EN
   logic              take2;
   res_t              s2;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         range_q <= '0;
         value_q <= '0;
         bn_q    <= BN_MIN;
         rem_q   <= '0;
         num_q   <= '0;
         bins_q  <= '0;
      end else begin
         state_q <= state_d;
         range_q <= range_d;
         value_q <= value_d;
         bn_q    <= bn_d;
         rem_q   <= rem_d;
         num_q   <= num_d;
         bins_q  <= bins_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      range_d      = range_q;
      value_d      = value_q;
      bn_d         = bn_q;
      rem_d        = rem_q;
      num_d        = num_q;
      bins_d       = bins_q;
      byte_ready_o = 1'b0;
      take1        = 1'b0;
`ifdef BYPASS_DUAL_BIN_EN
      take2        = 1'b0;
`endif

      if (req_num_i == 6'd0)               num_eff = 6'd1;
      else if (req_num_i > 6'(MAX_BINS))   num_eff = 6'(MAX_BINS);
      else                                 num_eff = req_num_i;

      s1 = bin_step(value_q, bn_q, range_q, byte_data_i, bn_q == BN_INS);
`ifdef BYPASS_DUAL_BIN_EN
      // Second bin is never an insert bin: the dual path is only taken
      // while bits_needed <= -3.
      s2 = bin_step(s1.val, s1.bn, range_q, byte_data_i, 1'b0);
`endif

      case (state_q)
         IDLE: begin
            if (req_valid_i) begin
               range_d = m_range_i;
               value_d = m_value_in_i;
               bn_d    = bits_needed_in_i;
               rem_d   = num_eff;
               num_d   = num_eff;
               bins_d  = '0;
               state_d = DECODE;
            end
         end
         DECODE: begin
            if (bn_q == BN_INS) begin
               if (byte_valid_i) begin
                  byte_ready_o = 1'b1;
                  take1        = 1'b1;
               end else begin
                  state_d = WAIT_BYTE;
               end
            end
`ifdef BYPASS_DUAL_BIN_EN
            else if (rem_q >= 6'd2 && bn_q <= -4'sd3) begin
               take2 = 1'b1;
            end
`endif
            else begin
               take1 = 1'b1;
            end
         end
         WAIT_BYTE: begin
            if (byte_valid_i) begin
               byte_ready_o = 1'b1;
               take1        = 1'b1;
            end
         end
         DONE: begin
            if (bins_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (take1) begin
         value_d = s1.val;
         bn_d    = s1.bn;
         bins_d  = {bins_q[30:0], s1.bin};
         rem_d   = rem_q - 6'd1;
         state_d = (rem_d == 6'd0) ? DONE : DECODE;
      end
`ifdef BYPASS_DUAL_BIN_EN
      if (take2) begin
         value_d = s2.val;
         bn_d    = s2.bn;
         bins_d  = {bins_q[29:0], s1.bin, s2.bin};
         rem_d   = rem_q - 6'd2;
         state_d = (rem_d == 6'd0) ? DONE : DECODE;
      end
`endif
   end

   assign req_ready_o       = (state_q == IDLE);
   assign bins_valid_o      = (state_q == DONE);
   assign bins_data_o       = bins_q;
   assign bins_num_o        = num_q;
   assign m_value_out_o     = value_q;
   assign bits_needed_out_o = bn_q;

endmodule

// File: tb/tb_bypass_bin_sched.sv
// Directed bench for bypass_bin_sched with a queue-based scoreboard.
module tb_bypass_bin_sched;

   typedef struct {
      logic [31:0] data;
      int          num;
      logic [15:0] val;
      logic [3:0]  bn;
      int          lat;
      int          bytes;
   } exp_t;

`ifdef BYPASS_DUAL_BIN_EN
   localparam bit DUAL = 1'b1;
`else
   localparam bit DUAL = 1'b0;
`endif

   logic              clk, rst;
   logic              req_valid, req_ready;
   logic [5:0]        req_num;
   logic [8:0]        m_range;
   logic [15:0]       m_value_in;
   logic signed [3:0] bits_needed_in;
   logic              byte_valid, byte_ready;
   logic [7:0]        byte_data;
   logic              bins_valid, bins_ready;
   logic [31:0]       bins_data;
   logic [5:0]        bins_num;
   logic [15:0]       m_value_out;
   logic signed [3:0] bits_needed_out;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   acc_cyc = 0;
   int   nbytes = 0;
   bit   vld_prev = 1'b0;
   exp_t q[$];
   exp_t e;

   bypass_bin_sched dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_num_i(req_num), .m_range_i(m_range),
      .m_value_in_i(m_value_in), .bits_needed_in_i(bits_needed_in),
      .byte_valid_i(byte_valid), .byte_ready_o(byte_ready),
      .byte_data_i(byte_data),
      .bins_valid_o(bins_valid), .bins_ready_i(bins_ready),
      .bins_data_o(bins_data), .bins_num_o(bins_num),
      .m_value_out_o(m_value_out), .bits_needed_out_o(bits_needed_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] d, input int n, input logic [15:0] v,
                               input logic [3:0] b, input int lat_s, input int lat_d,
                               input int by);
      exp_t r;
      r.data = d; r.num = n; r.val = v; r.bn = b;
      r.lat = DUAL ? lat_d : lat_s; r.bytes = by;
      return r;
   endfunction

   // Monitor: latency, stability under back-pressure, result fields, byte count.
   always @(negedge clk) begin
      if (rst) begin
         vld_prev = 1'b0;
      end else begin
         if (byte_ready && !byte_valid) begin
            checks++; errors++;
            $display("FAIL byte_ready_without_valid: got 1 expected 0");
         end
         if (byte_valid && byte_ready) nbytes++;
         if (req_valid && req_ready) begin acc_cyc = cyc; nbytes = 0; end
         if (bins_valid) begin
            if (q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_bins_valid: got 1 expected 0");
            end else begin
               e = q[0];
               if (!vld_prev) chk("latency", cyc - acc_cyc, e.lat);
               chk("bins_data", bins_data, e.data);
               chk("bins_num", {26'd0, bins_num}, e.num);
               chk("m_value_out", {16'd0, m_value_out}, {16'd0, e.val});
               chk("bits_needed_out", {28'd0, bits_needed_out}, {28'd0, e.bn});
               chk("req_ready_in_done", {31'd0, req_ready}, 32'd0);
               if (bins_ready) begin
                  chk("bytes_consumed", nbytes, e.bytes);
                  void'(q.pop_front());
               end
            end
         end
         vld_prev = bins_valid;
      end
   end

   task automatic chk_reset(input string tag);
      chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
      chk({tag, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
      chk({tag, "_bins_valid"}, {31'd0, bins_valid}, 32'd0);
      chk({tag, "_bins_data"}, bins_data, 32'd0);
      chk({tag, "_bins_num"}, {26'd0, bins_num}, 32'd0);
      chk({tag, "_m_value_out"}, {16'd0, m_value_out}, 32'd0);
      chk({tag, "_bits_needed_out"}, {28'd0, bits_needed_out}, 32'h8);
   endtask

   task automatic issue(input logic [8:0] rng, input logic [15:0] val, input logic [3:0] bn,
                        input logic [5:0] n, input bit push, input exp_t ex);
      int w = 0;
      while (!req_ready && w < 100) begin @(posedge clk); #1; w++; end
      if (!req_ready) begin
         checks++; errors++;
         $display("FAIL req_ready_timeout: got 0 expected 1");
         return;
      end
      if (push) q.push_back(ex);
      m_range = rng; m_value_in = val; bits_needed_in = bn; req_num = n;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_empty();
      int w = 0;
      while (q.size() != 0 && w < 300) begin @(posedge clk); #1; w++; end
      if (q.size() != 0) begin
         checks++; errors++;
         $display("FAIL result_timeout: got %0d pending expected 0", q.size());
         q.delete();
      end
   endtask

   initial begin
      int w;
      rst = 1'b1; req_valid = 1'b0; req_num = '0; m_range = '0; m_value_in = '0;
      bits_needed_in = '0; byte_valid = 1'b0; byte_data = '0; bins_ready = 1'b1;
      repeat (3) @(posedge clk); #1;
      chk_reset("por");
      rst = 1'b0;
      @(posedge clk); #1;

      // one bin
      issue(9'd256, 16'h4000, 4'h8, 6'd1, 1'b1, mk(32'h1, 1, 16'h0000, 4'h9, 2, 2, 0));
      wait_empty();
      // two bins
      issue(9'd256, 16'h6000, 4'h8, 6'd2, 1'b1, mk(32'h3, 2, 16'h0000, 4'hA, 3, 2, 0));
      wait_empty();
      // mixed bins, range 300: 1,0,0
      issue(9'd300, 16'h5000, 4'h8, 6'd3, 1'b1, mk(32'h4, 3, 16'h2800, 4'hB, 4, 3, 0));
      wait_empty();
      // req_num = 0 behaves as 1
      issue(9'd256, 16'h4000, 4'h8, 6'd0, 1'b1, mk(32'h1, 1, 16'h0000, 4'h9, 2, 2, 0));
      wait_empty();

      // byte insert, byte already available
      byte_valid = 1'b1; byte_data = 8'hFF;
      issue(9'd256, 16'h7F80, 4'hF, 6'd1, 1'b1, mk(32'h1, 1, 16'h7FFF, 4'h8, 2, 2, 1));
      wait_empty();
      byte_valid = 1'b0;

      // byte stall: byte_valid low for 3 insert cycles
      issue(9'd256, 16'h7F80, 4'hF, 6'd1, 1'b1, mk(32'h1, 1, 16'h7FFF, 4'h8, 5, 5, 1));
      repeat (3) @(posedge clk); #1;
      byte_valid = 1'b1;
      wait_empty();
      byte_valid = 1'b0;

      // back-pressure on a 32-bin request with 4 byte inserts
      byte_valid = 1'b1; byte_data = 8'h80; bins_ready = 1'b0;
      issue(9'd256, 16'h0000, 4'h8, 6'd32, 1'b1,
            mk(32'h0001_0101, 32, 16'h0080, 4'h8, 33, 21, 4));
      w = 0;
      while (!bins_valid && w < 100) begin @(posedge clk); #1; w++; end
      if (!bins_valid) begin
         checks++; errors++;
         $display("FAIL bins_valid_timeout: got 0 expected 1");
      end
      repeat (5) @(posedge clk); #1;
      bins_ready = 1'b1;
      wait_empty();
      chk("idle_after_done", {31'd0, req_ready}, 32'd1);

      // reset in the middle of an 8-bin request, then reissue
      issue(9'd256, 16'h4000, 4'h8, 6'd8, 1'b0, mk(32'h80, 8, 16'h0080, 4'h8, 9, 6, 1));
      repeat (3) @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk_reset("mid");
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      issue(9'd256, 16'h4000, 4'h8, 6'd8, 1'b1, mk(32'h80, 8, 16'h0080, 4'h8, 9, 6, 1));
      wait_empty();
      byte_valid = 1'b0;

      repeat (3) @(posedge clk); #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bypass_bin_sched.md
# bypass_bin_sched

Sequencer for the equiprobable (bypass) bin path of the VVC arithmetic decoder. It accepts a request for 1–32 bypass bins from the syntax-element parser and steps the bypass datapath one bin per cycle, or two per cycle when `BYPASS_DUAL_BIN_EN` is defined. It inserts bitstream bytes when the offset register runs dry and returns the packed bins together with the updated `m_value` and `bits_needed` to the context engine.

## Interface
- `MAX_BINS`, default 32: maximum bins per request. `req_num` and `bins_num` are 6 bits wide.
- `clk` input, 1 bit: the only clock. All state updates on its rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `req_valid` / `req_ready`, in/out, 1 bit each: request handshake.
- `req_num` input, 6 bits: number of bins requested, 1..MAX_BINS.
- `m_range` input, 9 bits: arithmetic range, 256..510. Latched on request accept.
- `m_value_in` input, 16 bits: offset value. Latched on request accept.
- `bits_needed_in` input, 4 bits signed: -8..-1. Latched on request accept.
- `byte_valid` / `byte_ready`, in/out, 1 bit each: bitstream byte handshake.
- `byte_data` input, 8 bits: bitstream byte.
- `bins_valid` / `bins_ready`, out/in, 1 bit each: result handshake.
- `bins_data` output, 32 bits: decoded bins, LSB-aligned. The first decoded bin is at bit `bins_num-1`.
- `bins_num` output, 6 bits: echo of `req_num`.
- `m_value_out` output, 16 bits: updated offset value.
- `bits_needed_out` output, 4 bits signed: updated bits-needed count.

## Operation
- **State IDLE.**
  - `req_ready` = 1.
  - When `req_valid` is high: latch all request inputs, set `rem` = `req_num`, clear `bins_data`, go to DECODE.
  - `req_num` = 0 is illegal; the block treats it as 1.
- **Per-bin arithmetic** (17-bit):
  - `scaled` = `m_range` << 7.
  - `v` = `value` << 1. If `bits_needed` = -1, also add `byte_data` (byte-insert bin).
  - bin = (`v` ≥ `scaled`). `value` = bin ? `v` − `scaled` : `v`, truncated to 16 bits.
  - `bits_needed` increments per bin and wraps to -8 on a byte-insert bin.
  - `bins_data` = {`bins_data`, bin}. `rem` decrements per bin.
- **Caller precondition** (not checked): `m_value_in` < `scaled`, and its low (8 + `bits_needed_in`) bits are zero.
- **State DECODE.**
  - Byte-insert bin:
    - If `byte_valid` is high, assert `byte_ready` combinationally, consume the byte, and decode the bin this cycle.
    - Otherwise go to WAIT_BYTE. No bin is decoded that cycle.
  - Two-bin cycle, only with `BYPASS_DUAL_BIN_EN`: taken when `rem` ≥ 2 and `bits_needed` ≤ -3. The second bin uses the first bin's resulting `value`.
  - Otherwise one bin is decoded per cycle.
  - When `rem` reaches 0, go to DONE.
- **State WAIT_BYTE.**
  - Waits for `byte_valid`.
  - On the cycle `byte_valid` is high: assert `byte_ready`, decode the byte-insert bin, then return to DECODE, or go to DONE if `rem` reaches 0.
- **State DONE.**
  - `bins_valid` = 1. Result outputs are held stable until `bins_ready` is high, then go to IDLE.
  - `req_ready` = 0 in DONE. A new request is accepted no earlier than the cycle after the DONE handshake.
- `byte_ready` is never asserted outside byte-insert cycles.
- Reset mid-operation: the block returns to IDLE immediately. Any partially consumed request is discarded, and the caller must reissue it.

## Timing
- Reset values:
  - state = IDLE, so `req_ready` = 1.
  - `byte_ready` = 0, `bins_valid` = 0.
  - `bins_data` = 0, `bins_num` = 0, `m_value_out` = 0.
  - `bits_needed_out` = -8.
- Single-bin build latency: accept edge → N decode cycles (+1 per cycle spent waiting for a byte) → DONE.
  - `bins_valid` rises on the edge after the last bin.
  - Minimum latency is N+1 cycles from accept to `bins_valid`.
- Dual-bin build: each two-bin cycle saves one cycle. The minimum is ceil(N/2)+1 when no bytes are inserted.
- All outputs are registered, except `byte_ready`, which is combinational from state, `bits_needed` and `byte_valid`.

## Configuration
- `BYPASS_DUAL_BIN_EN` defined: the two-bin-per-cycle path is compiled in. This uses a second compare/subtract stage chained after the first.
- `BYPASS_DUAL_BIN_EN` not defined: strictly one bin per cycle, with a single compare/subtract. Results are bit-identical in both builds; only cycle counts differ.

## Test plan
- **One bin:** range 256, value 0x4000, bits -8, N=1 → bin 1, `m_value_out` 0x0000, `bits_needed_out` -7, `bins_valid` 2 cycles after accept.
- **Two bins:** range 256, value 0x6000, bits -8, N=2 → `bins_data` 0b11, value 0x0000, bits -6. Takes 2 decode cycles single, 1 cycle dual.
- **Byte insert:** range 256, value 0x7F80, bits -1, N=1, byte 0xFF → bin 1, value 0x7FFF, bits -8, `byte_ready` pulsed exactly once.
- **Byte stall:** same as byte insert, but `byte_valid` is held low for 3 cycles → block sits in WAIT_BYTE, `byte_ready` = 0, result identical, latency +3.
- **Back-pressure:** N=32, value 0, `bins_ready` low for 5 cycles → all outputs held stable, `req_ready` stays 0, then IDLE.
- **Reset mid-request:** assert `rst` after 3 bins of an N=8 request → state IDLE, all outputs at reset values; a re-issued request then completes correctly.
